ldst_mem_sequencer: RTL

- Controller and arbiter for the load/store unit's single-ported data-memory block array.
- Takes load requests and store requests, serialises them onto one synchronous memory port, and returns whole fetched blocks to the load writeback stage.
- Performs read-modify-write for sub-block stores of byte, halfword, word and doubleword size.
- Sits between the load/store issue stage and the data memory, and replaces direct per-stage memory access.

---
 rtl/ldst_mem_sequencer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ldst_mem_sequencer.sv
// Load/store sequencer: arbitrates load and store requests onto one synchronous
// data-memory port, returns fetched blocks and performs read-modify-write stores.
module ldst_mem_sequencer #(
    parameter int unsigned memoryBlockSize = 128,
    parameter int unsigned numMemoryBlocks = 128,
    parameter int unsigned addressSize     = 64,
    parameter int unsigned tagWidth        = 6,
    localparam int unsigned blockIndexWidth = $clog2(numMemoryBlocks),
    localparam int unsigned byteOffsetWidth = $clog2(memoryBlockSize / 8)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       ldReq_i,
    input  logic [addressSize-1:0]     ldAddr_i,
    input  logic [tagWidth-1:0]        ldTag_i,
    output logic                       ldGnt_o,
    input  logic                       stReq_i,
    input  logic [addressSize-1:0]     stAddr_i,
    input  logic [63:0]                stData_i,
    input  logic [2:0]                 stSize_i,
    output logic                       stGnt_o,
    output logic                       stErr_o,
    output logic                       memEn_o,
    output logic                       memWe_o,
    output logic [blockIndexWidth-1:0] memIndex_o,
    output logic [memoryBlockSize-1:0] memWData_o,
    input  logic [memoryBlockSize-1:0] memRData_i,
    output logic                       ldValid_o,
    output logic [tagWidth-1:0]        ldTag_o,
    output logic [memoryBlockSize-1:0] ldBlock_o,
    output logic [byteOffsetWidth-1:0] ldOffset_o,
    output logic                       busy_o
);

    localparam int unsigned BLOCK_BYTES = memoryBlockSize / 8;
    localparam int unsigned ST_DATA_W   = 64;
    localparam int unsigned ST_N_W      = 4;
    localparam int unsigned IDX_HI      = byteOffsetWidth + blockIndexWidth;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_RET,
        S_ST_MRG,
        S_WR
    } state_e;

    state_e                     state_q, state_d;
    logic                       prio_st_q, prio_st_d;
    logic                       is_st_q, is_st_d;
    logic                       err_q, err_d;
    logic [blockIndexWidth-1:0] index_q, index_d;
    logic [byteOffsetWidth-1:0] offset_q, offset_d;
    logic [tagWidth-1:0]        tag_q, tag_d;
    logic [ST_DATA_W-1:0]       st_data_q, st_data_d;
    logic [ST_N_W-1:0]          st_n_q, st_n_d;

    logic                       ld_gnt_q, ld_gnt_d;
    logic                       st_gnt_q, st_gnt_d;
    logic                       st_err_q, st_err_d;
    logic                       mem_en_q, mem_en_d;
    logic                       mem_we_q, mem_we_d;
    logic [blockIndexWidth-1:0] mem_index_q, mem_index_d;
    logic [memoryBlockSize-1:0] mem_wdata_q, mem_wdata_d;
    logic                       ld_valid_q, ld_valid_d;
    logic [tagWidth-1:0]        ld_tag_q, ld_tag_d;
    logic [memoryBlockSize-1:0] ld_block_q, ld_block_d;
    logic [byteOffsetWidth-1:0] ld_offset_q, ld_offset_d;
    logic                       busy_q, busy_d;

    logic [blockIndexWidth-1:0] ld_idx_c, st_idx_c;
    logic [byteOffsetWidth-1:0] ld_off_c, st_off_c;
    logic [ST_N_W-1:0]          st_n_c;
    logic                       st_size_bad_c, st_reject_c;
    logic                       ld_pick_c, st_pick_c;
    logic [memoryBlockSize-1:0] merged_c;
    logic                       unused_addr;

    assign ld_idx_c = ldAddr_i[byteOffsetWidth +: blockIndexWidth];
    assign st_idx_c = stAddr_i[byteOffsetWidth +: blockIndexWidth];
    assign ld_off_c = ldAddr_i[byteOffsetWidth-1:0];
    assign st_off_c = stAddr_i[byteOffsetWidth-1:0];

    // Address bits above the block index are ignored (index wraps).
    assign unused_addr = ^{ldAddr_i[addressSize-1:IDX_HI], stAddr_i[addressSize-1:IDX_HI]};

    // Store size decode and block-boundary check.
    always_comb begin
        st_n_c        = '0;
        st_size_bad_c = 1'b0;
        case (stSize_i)
            3'd1:    st_n_c = ST_N_W'(1);
            3'd2:    st_n_c = ST_N_W'(2);
            3'd3:    st_n_c = ST_N_W'(4);
            3'd4:    st_n_c = ST_N_W'(8);
            default: st_size_bad_c = 1'b1;
        endcase
        st_reject_c = st_size_bad_c ||
                      ((32'(st_off_c) + 32'(st_n_c)) > BLOCK_BYTES);
    end

    // Byte 0 is the most significant byte; the store value lands MSB first.
    always_comb begin
        merged_c = memRData_i;
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if ((k >= 32'(offset_q)) && (k < (32'(offset_q) + 32'(st_n_q)))) begin
                merged_c[memoryBlockSize - 1 - 8 * k -: 8] =
                    8'(st_data_q >> (8 * (32'(st_n_q) - 1 - (k - 32'(offset_q)))));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_st_d   = prio_st_q;
        is_st_d     = is_st_q;
        err_d       = err_q;
        index_d     = index_q;
        offset_d    = offset_q;
        tag_d       = tag_q;
        st_data_d   = st_data_q;
        st_n_d      = st_n_q;
        ld_gnt_d    = 1'b0;
        st_gnt_d    = 1'b0;
        st_err_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_index_d = mem_index_q;
        mem_wdata_d = mem_wdata_q;
        ld_valid_d  = 1'b0;
        ld_tag_d    = ld_tag_q;
        ld_block_d  = ld_block_q;
        ld_offset_d = ld_offset_q;
        ld_pick_c   = 1'b0;
        st_pick_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ld_pick_c = ldReq_i && (!stReq_i || !prio_st_q);
                st_pick_c = stReq_i && !ld_pick_c;
                if (ld_pick_c) begin
                    is_st_d     = 1'b0;
                    err_d       = 1'b0;
                    index_d     = ld_idx_c;
                    offset_d    = ld_off_c;
                    tag_d       = ldTag_i;
                    ld_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_index_d = ld_idx_c;
                    prio_st_d   = 1'b1;
                    state_d     = S_RD;
                end else if (st_pick_c) begin
                    is_st_d   = 1'b1;
                    err_d     = st_reject_c;
                    index_d   = st_idx_c;
                    offset_d  = st_off_c;
                    st_data_d = stData_i;
                    st_n_d    = st_n_c;
                    st_gnt_d  = 1'b1;
                    st_err_d  = st_reject_c;
                    mem_en_d  = !st_reject_c;
                    if (!st_reject_c) begin
                        mem_index_d = st_idx_c;
                    end
                    prio_st_d = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (err_q) begin
                    state_d = S_IDLE;
                end else if (is_st_q) begin
                    state_d = S_ST_MRG;
                end else begin
                    state_d = S_LD_RET;
                end
            end
            S_LD_RET: begin
                ld_block_d  = memRData_i;
                ld_tag_d    = tag_q;
                ld_offset_d = offset_q;
                ld_valid_d  = 1'b1;
                state_d     = S_IDLE;
            end
            S_ST_MRG: begin
                mem_wdata_d = merged_c;
                mem_index_d = index_q;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                state_d     = S_WR;
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            prio_st_q   <= 1'b0;
            is_st_q     <= 1'b0;
            err_q       <= 1'b0;
            index_q     <= '0;
            offset_q    <= '0;
            tag_q       <= '0;
            st_data_q   <= '0;
            st_n_q      <= '0;
            ld_gnt_q    <= 1'b0;
            st_gnt_q    <= 1'b0;
            st_err_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_index_q <= '0;
            mem_wdata_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_tag_q    <= '0;
            ld_block_q  <= '0;
            ld_offset_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_st_q   <= prio_st_d;
            is_st_q     <= is_st_d;
            err_q       <= err_d;
            index_q     <= index_d;
            offset_q    <= offset_d;
            tag_q       <= tag_d;
            st_data_q   <= st_data_d;
            st_n_q      <= st_n_d;
            ld_gnt_q    <= ld_gnt_d;
            st_gnt_q    <= st_gnt_d;
            st_err_q    <= st_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_index_q <= mem_index_d;
            mem_wdata_q <= mem_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_tag_q    <= ld_tag_d;
            ld_block_q  <= ld_block_d;
            ld_offset_q <= ld_offset_d;
            busy_q      <= busy_d;
        end
    end

    assign ldGnt_o    = ld_gnt_q;
    assign stGnt_o    = st_gnt_q;
    assign stErr_o    = st_err_q;
    assign memEn_o    = mem_en_q;
    assign memWe_o    = mem_we_q;
    assign memIndex_o = mem_index_q;
    assign memWData_o = mem_wdata_q;
    assign ldValid_o  = ld_valid_q;
    assign ldTag_o    = ld_tag_q;
    assign ldBlock_o  = ld_block_q;
    assign ldOffset_o = ld_offset_q;
    assign busy_o     = busy_q;

endmodule
